shift_seq_ctrl: RTL and testbench

- Command sequencer for the 8-bit shift register (parallel-load / shift-toward-MSB / shift-toward-LSB, controlled by enable, shift_direction, data_in).
- Accepts one command at a time over a valid/ready handshake and drives the register's control inputs for the required number of cycles.
- Returns the resulting register contents over a valid/ready response channel.
- Sits between a software/host command source and the shift register instance; the shift register shares clk and reset with this block.

---
 rtl/shift_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for an 8-bit load/shift register.
// Takes one command at a time, drives the register's enable/direction/data
// for the required number of cycles, then presents the register contents
// on a response channel until the host consumes them.
//
//   state | meaning
//   IDLE  | ready for a command, register untouched
//   LOAD  | one cycle of parallel load with the latched data
//   SHIFT | shifting, one cycle per remaining count
//   RESP  | register frozen, result offered until rsp_ready
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic             sr_enable,
    output logic [1:0]       sr_dir,
    output logic [WIDTH-1:0] sr_data,
    input  logic [WIDTH-1:0] sr_q
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_SHL      = 2'b01;
    localparam logic [1:0] OP_LOAD_SHR = 2'b11;

    localparam logic [1:0] DIR_LOAD = 2'b11;
    localparam logic [1:0] DIR_MSB  = 2'b00;
    localparam logic [1:0] DIR_LSB  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;

    // State and latched command registers; reset aborts any command in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= 2'b00;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Next state and all outputs; outputs are decoded from state so reset
    // drops sr_enable immediately.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        busy      = 1'b1;
        sr_enable = 1'b0;
        sr_dir    = DIR_MSB;
        sr_data   = '0;

        case (state_q)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    cnt_d  = cmd_count;
                    data_d = cmd_data;
                    if (cmd_op == OP_LOAD || cmd_op == OP_LOAD_SHR) begin
                        state_d = ST_LOAD;
                    end else if (cmd_count != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end

            ST_LOAD: begin
                sr_enable = 1'b1;
                sr_dir    = DIR_LOAD;
                sr_data   = data_q;
                // The counter still holds the command count, so it doubles
                // as the "any shifts after the load" test.
                if (op_q == OP_LOAD_SHR && cnt_q != '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_RESP;
                end
            end

            ST_SHIFT: begin
                sr_enable = 1'b1;
                sr_dir    = (op_q == OP_SHL) ? DIR_MSB : DIR_LSB;
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = sr_q;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: a zero-fill shift register model sits on the
// sr_* side, and every command's timing, enable pattern and result are
// predicted arithmetically from the command alone.
module tb_shift_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_count;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       busy;
    logic       sr_enable;
    logic [1:0] sr_dir;
    logic [7:0] sr_data;
    logic [7:0] sr_q;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] ref_reg;

    shift_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .sr_enable (sr_enable),
        .sr_dir    (sr_dir),
        .sr_data   (sr_data),
        .sr_q      (sr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached shift register: load on 11, toward MSB on 00, toward LSB on 10, zero fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= 8'h00;
        end else if (sr_enable) begin
            case (sr_dir)
                2'b11:   sr_q <= sr_data;
                2'b00:   sr_q <= {sr_q[6:0], 1'b0};
                2'b10:   sr_q <= {1'b0, sr_q[7:1]};
                default: sr_q <= sr_q;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command starting at a negedge while the DUT is idle; returns
    // at the negedge after the response handshake with the DUT idle again.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt,
                           input logic [7:0] data, input int hold, input bit hold_valid);
        int         n_load;
        int         n_shift;
        int         exp_resp;
        int         resp_k;
        int         en_seen;
        logic [7:0] exp_q;
        logic       exp_en;
        logic [1:0] exp_dir;
        logic [7:0] exp_dat;

        n_load   = (op == 2'b00 || op == 2'b11) ? 1 : 0;
        n_shift  = (op == 2'b00) ? 0 : int'(cnt);
        exp_resp = n_load + n_shift + 1;
        case (op)
            2'b00:   exp_q = data;
            2'b01:   exp_q = 8'((16'(ref_reg) << cnt) & 16'h00FF);
            2'b10:   exp_q = ref_reg >> cnt;
            default: exp_q = data >> cnt;
        endcase

        check("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_count = 4'($urandom);
        cmd_data  = 8'($urandom);

        resp_k  = 0;
        en_seen = 0;
        for (int k = 1; k <= 40 && resp_k == 0; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                resp_k    = k;
                rsp_ready = 1'b0;
            end else begin
                exp_en  = (k <= n_load + n_shift);
                exp_dir = !exp_en ? 2'b00 : (n_load == 1 && k == 1) ? 2'b11 :
                          (op == 2'b01) ? 2'b00 : 2'b10;
                exp_dat = (exp_en && n_load == 1 && k == 1) ? data : 8'h00;
                check("run_sr_enable", sr_enable, exp_en);
                check("run_sr_dir", sr_dir, exp_dir);
                check("run_sr_data", sr_data, exp_dat);
                check("run_busy", busy, 1);
                check("run_cmd_ready", cmd_ready, 0);
                if (sr_enable) en_seen++;
                rsp_ready = 1'($urandom);
            end
        end

        check("resp_cycle", resp_k, exp_resp);
        check("enable_cycles", en_seen, n_load + n_shift);
        check("rsp_data", rsp_data, exp_q);
        check("resp_sr_enable", sr_enable, 0);
        check("resp_busy", busy, 1);

        for (int h = 0; h < hold; h++) begin
            if (hold_valid) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'($urandom);
                cmd_count = 4'($urandom);
                cmd_data  = 8'($urandom);
            end
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_data", rsp_data, exp_q);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_sr_enable", sr_enable, 0);
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_busy", busy, 0);
        check("post_cmd_ready", cmd_ready, 1);
        check("post_sr_q", sr_q, exp_q);
        ref_reg = exp_q;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_count = 4'd0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        ref_reg   = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sr_enable", sr_enable, 0);
        check("rst_sr_dir", sr_dir, 0);
        check("rst_sr_data", sr_data, 0);
        reset = 1'b0;

        // Reset in the middle of a 10-shift command, after three shifts.
        run_cmd(2'b00, 4'd0, 8'h3C, 0, 0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_count = 4'd10;
        cmd_data  = 8'h00;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("abort_pre_enable", sr_enable, 1);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_sr_enable", sr_enable, 0);
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 0);
        end
        reset   = 1'b0;
        ref_reg = 8'h00;
        @(negedge clk);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_no_rsp_after", rsp_valid, 0);

        run_cmd(2'b00, 4'd7, 8'hA5, 0, 0);   // LOAD A5
        run_cmd(2'b00, 4'd0, 8'h81, 0, 0);   // LOAD 81
        run_cmd(2'b10, 4'd3, 8'hFF, 0, 0);   // SHR 3 -> 10
        run_cmd(2'b11, 4'd4, 8'hF0, 1, 0);   // LOAD_SHR F0,4 -> 0F
        run_cmd(2'b01, 4'd0, 8'h55, 0, 0);   // SHL 0 -> unchanged
        run_cmd(2'b01, 4'd2, 8'h00, 5, 1);   // response stalled 5 cycles, cmd_valid high
        run_cmd(2'b11, 4'd15, 8'hFF, 0, 0);  // maximum count
        run_cmd(2'b11, 4'd0, 8'h6B, 2, 1);   // LOAD_SHR with zero count

        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
